// File: rtl/dvs_pkg.sv
// Shared types and constants for the DVS address-event extractor.
package dvs_pkg;

  // Frame geometry
  localparam int ROW_PIXELS       = 128;
  localparam int ROWS_PER_BLOCK   = 32;
  localparam int WORDS_PER_ROW    = 64;
  localparam int BLOCK_WORDS      = 2048;
  localparam int BLOCKS_PER_FRAME = 4;
  localparam int FIFO_DEPTH       = 16;

  localparam int ADDR_W  = $clog2(BLOCK_WORDS);
  localparam int COORD_W = $clog2(ROW_PIXELS);

  // Event word layout: {pol, y, x}
  localparam int EVT_W       = 1 + 2 * COORD_W;
  localparam int EVT_POL_BIT = 14;
  localparam int EVT_Y_LSB   = 7;
  localparam int EVT_X_LSB   = 0;

  // Colour field positions inside a BRAM word (high pixel, low pixel)
  localparam int COL0_LSB = 22;
  localparam int COL1_LSB = 6;

  localparam logic [1:0] COL_NONE = 2'b00;
  localparam logic [1:0] COL_POS  = 2'b01;
  localparam logic [1:0] COL_NEG  = 2'b10;
  localparam logic [1:0] COL_BAD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    PUSH_HI,
    PUSH_LO
  } state_e;

  function automatic logic is_event(input logic [1:0] col);
    return (col == COL_POS) || (col == COL_NEG);
  endfunction

endpackage

// File: rtl/dvs_evt_fifo.sv
// First-word fall-through event FIFO; data_o reads as zero while empty.
module dvs_evt_fifo
  import dvs_pkg::*;
#(
  parameter int WIDTH = EVT_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q, wr_d;
  logic [PW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q[PW-1:0]];

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_comb begin
    wr_d = wr_q + (PW+1)'(do_push);
    rd_d = rd_q + (PW+1)'(do_pop);
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents need no reset since empty masks the output.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/dvs_event_extract.sv
// Scans a 32x128 change-detection block from BRAM and emits address-events.
//
//  state   | meaning
//  IDLE    | waiting for block-ready edge
//  RD_ADDR | bram_en high, address presented
//  RD_DATA | BRAM data valid, colour fields captured
//  PUSH_HI | emit event for even pixel (stalls while FIFO full)
//  PUSH_LO | emit event for odd pixel, then next word or block done
module dvs_event_extract
  import dvs_pkg::*;
(
  input  logic              pclk,
  input  logic              reset,
  input  logic              new_frame,
  input  logic              write_new_line,
  output logic [31:0]       bram_addr,
  output logic              bram_clk,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [31:0]       bram_wrdata,
  output logic              bram_rst,
  input  logic [31:0]       bram_rddata,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [EVT_W-1:0]  evt_data,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       bad_colour_cnt
);

  localparam logic [2:0]        BLK_DONE  = 3'(BLOCKS_PER_FRAME);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        blk_q, blk_d;
  logic [3:0]        col_q, col_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       bad_q, bad_d;
  logic              wnl_q;

  logic              trigger, in_push, lo_half, evt_now, stall, push;
  logic [1:0]        cur_col;
  logic [EVT_W-1:0]  push_data;
  logic              fifo_full, fifo_empty;
  logic              unused_rddata;

  assign trigger   = write_new_line & ~wnl_q;
  assign in_push   = (state_q == PUSH_HI) || (state_q == PUSH_LO);
  assign lo_half   = (state_q == PUSH_LO);
  assign cur_col   = lo_half ? col_q[1:0] : col_q[3:2];
  assign evt_now   = in_push & is_event(cur_col);
  assign stall     = evt_now & fifo_full;
  assign push      = evt_now & ~fifo_full & ~new_frame;
  // y = blk*32 + row, x = 2*word_in_row + half
  assign push_data = {cur_col == COL_POS, blk_q[1:0], addr_q[ADDR_W-1:6], addr_q[5:0], lo_half};

  // Next-state, address, block and status logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    blk_d     = blk_q;
    col_d     = col_q;
    overrun_d = overrun_q;
    bad_d     = bad_q;

    case (state_q)
      IDLE: begin
        if (trigger && (blk_q < BLK_DONE)) begin
          state_d = RD_ADDR;
          addr_d  = '0;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        col_d   = {bram_rddata[COL0_LSB +: 2], bram_rddata[COL1_LSB +: 2]};
        state_d = PUSH_HI;
      end
      PUSH_HI: begin
        if (!stall) state_d = PUSH_LO;
      end
      PUSH_LO: begin
        if (!stall) begin
          if (addr_q == LAST_ADDR) begin
            if (blk_q < BLK_DONE) blk_d = blk_q + 3'd1;
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = RD_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A bad code is never an event, so each PUSH state counts it once.
    if (in_push && (cur_col == COL_BAD) && (bad_q != 16'hFFFF)) bad_d = bad_q + 16'd1;

    if (trigger && ((state_q != IDLE) || (blk_q >= BLK_DONE))) overrun_d = 1'b1;

    if (new_frame) begin
      state_d   = IDLE;
      addr_d    = '0;
      blk_d     = '0;
      overrun_d = 1'b0;
      bad_d     = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      blk_q     <= '0;
      col_q     <= '0;
      overrun_q <= 1'b0;
      bad_q     <= '0;
      wnl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      blk_q     <= blk_d;
      col_q     <= col_d;
      overrun_q <= overrun_d;
      bad_q     <= bad_d;
      wnl_q     <= write_new_line;
    end
  end

  dvs_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (pclk),
    .rst_i   (reset),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (evt_ready),
    .data_o  (evt_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid      = ~fifo_empty;
  assign bram_addr      = {{(32-ADDR_W){1'b0}}, addr_q};
  assign bram_clk       = pclk;
  assign bram_rst       = reset;
  assign bram_en        = (state_q == RD_ADDR);
  assign bram_we        = '0;
  assign bram_wrdata    = '0;
  assign busy           = (state_q != IDLE);
  assign overrun        = overrun_q;
  assign bad_colour_cnt = bad_q;

  // Reference and pixel-value fields are not needed for event extraction.
  assign unused_rddata = ^{bram_rddata[31:24], bram_rddata[21:8], bram_rddata[5:0]};

endmodule

// File: tb/tb_dvs_event_extract.sv
// Directed bench for dvs_event_extract with a BRAM model and event scoreboard.
module tb_dvs_event_extract;

  logic        pclk = 1'b0;
  logic        reset, new_frame, write_new_line, evt_ready;
  logic [31:0] bram_addr, bram_wrdata, bram_rddata;
  logic        bram_clk, bram_en, bram_rst;
  logic [3:0]  bram_we;
  logic        evt_valid, busy, overrun;
  logic [14:0] evt_data;
  logic [15:0] bad_colour_cnt;

  logic [31:0] mem [2048];
  logic [14:0] sb [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cnt;

  dvs_event_extract dut (
    .pclk           (pclk),
    .reset          (reset),
    .new_frame      (new_frame),
    .write_new_line (write_new_line),
    .bram_addr      (bram_addr),
    .bram_clk       (bram_clk),
    .bram_en        (bram_en),
    .bram_we        (bram_we),
    .bram_wrdata    (bram_wrdata),
    .bram_rst       (bram_rst),
    .bram_rddata    (bram_rddata),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_data       (evt_data),
    .busy           (busy),
    .overrun        (overrun),
    .bad_colour_cnt (bad_colour_cnt)
  );

  always #5 pclk = ~pclk;

  // One-cycle-latency BRAM read port.
  initial bram_rddata = '0;
  always @(posedge pclk) if (bram_en) bram_rddata <= mem[bram_addr[10:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] mk_evt(input logic pol, input int y, input int x);
    logic [6:0] yy, xx;
    yy = y[6:0];
    xx = x[6:0];
    return {pol, yy, xx};
  endfunction

  task automatic expect_block(input int blk, input int max_evts);
    int n;
    logic [31:0] w;
    logic [1:0] c;
    n = 0;
    for (int a = 0; a < 2048; a++) begin
      w = mem[a];
      for (int h = 0; h < 2; h++) begin
        c = (h == 0) ? w[23:22] : w[7:6];
        if ((c == 2'b01 || c == 2'b10) && n < max_evts) begin
          sb.push_back(mk_evt(c == 2'b01, blk * 32 + a / 64, (a % 64) * 2 + h));
          n++;
        end
      end
    end
  endtask

  task automatic fill(input logic [31:0] v);
    for (int a = 0; a < 2048; a++) mem[a] = v;
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic trig(input int len);
    write_new_line = 1'b1;
    repeat (len) tick();
    write_new_line = 1'b0;
  endtask

  task automatic pulse_new_frame;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 20000) begin
      tick();
      n++;
    end
    check("scan_finished", busy, 1'b0);
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while ((sb.size() != 0 || evt_valid) && n < 10000) begin
      tick();
      n++;
    end
    check("drain_sb_empty", sb.size(), 0);
    check("drain_valid_low", evt_valid, 1'b0);
  endtask

  // Scoreboard: every accepted event must match the head of the expected queue.
  always @(negedge pclk) begin
    if (!reset && evt_valid && evt_ready) begin
      check("evt_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) check("evt_data", evt_data, sb.pop_front());
    end
  end

  initial begin
    reset = 1'b1; new_frame = 1'b0; write_new_line = 1'b0; evt_ready = 1'b0;
    fill(32'h0);
    repeat (3) tick();
    reset = 1'b0;

    check("rst_evt_valid", evt_valid, 1'b0);
    check("rst_evt_data", evt_data, 15'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_bad_cnt", bad_colour_cnt, 16'h0);
    check("rst_bram_addr", bram_addr, 32'h0);
    check("rst_bram_en", bram_en, 1'b0);
    check("bram_we", bram_we, 4'h0);

    // Block 0: two events in word 0, timing checks
    mem[0] = 32'h0040_0080;
    evt_ready = 1'b1;
    expect_block(0, 1 << 30);
    trig(1);
    check("trig_busy", busy, 1'b1);
    check("trig_bram_en", bram_en, 1'b1);
    check("trig_addr", bram_addr, 32'd0);
    tick();
    check("rd_data_en_low", bram_en, 1'b0);
    tick();
    check("pre_push_valid", evt_valid, 1'b0);
    tick();
    check("push_valid", evt_valid, 1'b1);
    tick();
    check("word1_addr", bram_addr, 32'd1);
    check("word1_en", bram_en, 1'b1);
    cnt = 5;
    tick();
    while (busy && cnt < 20000) begin
      cnt++;
      tick();
    end
    check("busy_cycles", cnt, 8192);
    wait_drain();

    // Block 1: all bad colour codes, 2-cycle trigger
    fill(32'h00C0_00C0);
    expect_block(1, 1 << 30);
    trig(2);
    wait_idle();
    check("bad_cnt", bad_colour_cnt, 16'd4096);
    check("no_overrun_2cyc", overrun, 1'b0);
    wait_drain();

    // Block 2: single event in last word
    fill(32'h0);
    mem[2047] = 32'h0040_0000;
    expect_block(2, 1 << 30);
    trig(1);
    wait_idle();
    wait_drain();
    check("bad_cnt_kept", bad_colour_cnt, 16'd4096);

    // Block 3: every pixel positive, consumer stalled
    fill(32'h0040_0040);
    evt_ready = 1'b0;
    expect_block(3, 1 << 30);
    trig(1);
    repeat (200) tick();
    check("stall_valid", evt_valid, 1'b1);
    check("stall_busy", busy, 1'b1);
    check("stall_addr", bram_addr, 32'd8);
    check("stall_en", bram_en, 1'b0);
    evt_ready = 1'b1;
    wait_idle();
    wait_drain();

    // Fifth trigger in the frame
    check("pre5_overrun", overrun, 1'b0);
    trig(1);
    repeat (3) tick();
    check("fifth_busy", busy, 1'b0);
    check("fifth_overrun", overrun, 1'b1);
    pulse_new_frame();
    check("nf_overrun_clr", overrun, 1'b0);
    check("nf_bad_clr", bad_colour_cnt, 16'h0);

    // New frame: scan at blk 0 with a mid-scan trigger
    fill(32'h0);
    mem[2047] = 32'h0040_0080;
    expect_block(0, 1 << 30);
    trig(1);
    repeat (100) tick();
    trig(1);
    check("midscan_overrun", overrun, 1'b1);
    wait_idle();
    wait_drain();
    repeat (20) tick();
    check("no_extra_scan", busy, 1'b0);
    check("no_extra_events", sb.size(), 0);

    // Abort a stalled scan with new_frame; queued events survive
    pulse_new_frame();
    fill(32'h0040_0040);
    evt_ready = 1'b0;
    expect_block(0, 16);
    trig(1);
    repeat (200) tick();
    check("abort_pre_busy", busy, 1'b1);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    check("abort_busy", busy, 1'b0);
    tick();
    check("abort_fifo_kept", evt_valid, 1'b1);
    evt_ready = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
